m_axi_lite_master: RTL
======================

// Module: m_axi_lite_master
// PURPOSE
// - AXI4-Lite master (initiator) that turns single-beat register commands into AXI4-Lite write/read transactions.
// - Drives tDMA slave register ports (src/dst addr, config regs, PRNG seed, status/busy) from a test sequencer or host-side FSM.
// - One transaction outstanding at a time; the result is returned on a response port with valid/ready.
// PARAMETERS
// - C_PROT       3'b000   value driven on awprot_o/arprot_o
// - C_WSTRB      4'hF     value driven on wstrb_o for every write
// - C_TIMEOUT    16'd1024 watchdog limit in cycles per wait state (used only with M_AXI_TIMEOUT_EN)
// PORTS
// - aclk_i        in   1   clock
// - areset_i      in   1   synchronous reset, active-high
// - cmd_valid_i   in   1   command request
// - cmd_ready_o   out  1   command accepted when valid&ready
// - cmd_write_i   in   1   1=write, 0=read
// - cmd_addr_i    in   32  byte address
// - cmd_wdata_i   in   32  write data
// - rsp_valid_o   out  1   response available
// - rsp_ready_i   in   1   response consumed when valid&ready
// - rsp_rdata_o   out  32  read data (0 for writes)
// - rsp_resp_o    out  2   BRESP/RRESP captured from slave
// - rsp_timeout_o out  1   transaction aborted by watchdog
// - awvalid_o/awready_i/awaddr_o[31:0]/awprot_o[2:0]  AXI AW channel
// - wvalid_o/wready_i/wdata_o[31:0]/wstrb_o[3:0]      AXI W channel
// - bvalid_i/bready_o/bresp_i[1:0]                    AXI B channel
// - arvalid_o/arready_i/araddr_o[31:0]/arprot_o[2:0]  AXI AR channel
// - rvalid_i/rready_o/rdata_i[31:0]/rresp_i[1:0]      AXI R channel
// BEHAVIOUR
// - Reset: state=IDLE; every valid/ready output=0; awaddr_o/araddr_o/wdata_o/rsp_rdata_o=0; rsp_resp_o=2'b00; rsp_timeout_o=0.
// - All AXI and rsp outputs are registered except cmd_ready_o (= state==IDLE) and bready_o/rready_o (= state==WR_RESP/RD_DATA).
// - IDLE: cmd_valid_i -> latch addr/wdata; write -> WR_REQ with awvalid_o=wvalid_o=1 the next cycle; read -> RD_REQ with arvalid_o=1.
// - WR_REQ: AW and W are raised together in the same cycle (the slave waits for both). Each valid drops the cycle after its own
//   handshake; aw_done/w_done flags track this; ready on both in one cycle completes both. When both are done -> WR_RESP.
// - WR_RESP: bready_o=1; on bvalid_i capture bresp_i, rsp_rdata_o=0 -> RSP.
// - RD_REQ: arvalid_o held with stable araddr_o until arready_i -> RD_DATA. RD_DATA: rready_o=1; on rvalid_i capture rdata_i/rresp_i -> RSP.
// - RSP: rsp_valid_o=1 with data held stable until rsp_ready_i -> IDLE. The next cmd can be accepted at the earliest 1 cycle after.
// - Latency: the cmd handshake in cycle N puts AW/W/AR valid in cycle N+1; rsp_valid_o comes 1 cycle after the B/R handshake.
// - Valids never drop before their handshake; addr/data stay stable while valid (AXI rule), except on a watchdog abort.
// - A B/R beat is only taken in WR_RESP/RD_DATA. bvalid_i/rvalid_i seen in any other state is ignored (bready_o/rready_o=0).
// - areset_i mid-transaction: everything returns to reset values the next cycle and the in-flight command is lost with no response.
// CONFIGURATION
// - M_AXI_TIMEOUT_EN defined:
//   - A 16-bit counter clears on every state entry and counts while in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
//   - When the counter reaches C_TIMEOUT: force all AXI valids/readies to 0 and go to RSP with rsp_timeout_o=1, rsp_resp_o=2'b10, rsp_rdata_o=0.
//   - A handshake in the same cycle as the timeout wins; the watchdog is ignored that cycle.
// - M_AXI_TIMEOUT_EN undefined: no counter; rsp_timeout_o tied 0; the master waits forever.
// TESTING
// - Write 0x04 data 0xDEADBEEF; slave awready=wready=1 together 1 cycle after both valids, bresp=00 -> exactly one AW/W beat,
//   rsp_resp_o=00, rsp_rdata_o=0.
// - Write with wready 3 cycles before awready -> wvalid_o drops after its beat, awvalid_o held; one beat each; rsp once after bvalid.
// - Read 0x14; slave rdata=0x00000002, rresp=00 -> rsp_rdata_o=0x2, rsp_resp_o=00; araddr_o stable until arready_i.
// - Read 0x1C; slave rresp=10 -> rsp_resp_o=10. Hold rsp_ready_i=0 for 5 cycles -> rsp stable, cmd_ready_o=0 throughout.
// - M_AXI_TIMEOUT_EN, C_TIMEOUT=8, awready never asserted -> valids drop after 8 cycles, rsp_timeout_o=1, rsp_resp_o=10.
// - Pulse areset_i in WR_RESP before bvalid -> all outputs at reset values, cmd_ready_o=1 the next cycle, no rsp_valid_o.

Source files
------------

// File: rtl/m_axi_lite_master.sv
// m_axi_lite_master
//   AXI4-Lite initiator: converts single-beat register commands into one
//   AXI4-Lite write or read transaction at a time and returns the result
//   on a valid/ready response port.
//
// Optional feature macro: M_AXI_TIMEOUT_EN
//   defined   -> per-wait-state watchdog aborts a stalled transaction after
//                C_TIMEOUT cycles (rsp_timeout_o=1, rsp_resp_o=SLVERR)
//   undefined -> no watchdog, rsp_timeout_o tied low, master waits forever
//
// Ports
//   aclk_i, areset_i                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake (ready while idle)
//   cmd_write_i/cmd_addr_i/cmd_wdata_i  command payload
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_rdata_o/rsp_resp_o/rsp_timeout_o  response payload
//   aw*/w*/b*/ar*/r*                 AXI4-Lite master channels
module m_axi_lite_master #(
  parameter logic [2:0]  C_PROT    = 3'b000,
  parameter logic [3:0]  C_WSTRB   = 4'hF,
  parameter logic [15:0] C_TIMEOUT = 16'd1024
) (
  input  logic        aclk_i,
  input  logic        areset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        rsp_timeout_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awprot_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  output logic [2:0]  arprot_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        tmo_hit;
  logic        abort;
  logic        wr_hs;

  // Any AW or W beat this cycle; a beat beats the watchdog in the same cycle.
  assign wr_hs = (awvalid_q & awready_i) | (wvalid_q & wready_i);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_write_i) begin
            awaddr_d  = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = cmd_addr_i;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // A dropped valid doubles as the per-channel "done" flag.
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = S_WR_RESP;
        else                         abort   = tmo_hit & ~wr_hs;
      end
      S_WR_RESP: begin
        if (bvalid_i) begin
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp_i;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end else begin
          abort = tmo_hit;
        end
      end
      S_RD_REQ: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end else begin
          abort = tmo_hit;
        end
      end
      S_RD_DATA: begin
        if (rvalid_i) begin
          rsp_valid_d = 1'b1;
          rsp_resp_d  = rresp_i;
          rsp_rdata_d = rdata_i;
          state_d     = S_RSP;
        end else begin
          abort = tmo_hit;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort: withdraw every request and report SLVERR.
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_resp_d  = RESP_SLVERR;
      rsp_rdata_d = '0;
      state_d     = S_RSP;
    end
  end

  // State and output registers
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef M_AXI_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        in_wait;

  assign in_wait = state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA};
  // Fires in the cycle where the count would reach C_TIMEOUT; the >= keeps
  // it armed after a cycle where a handshake pre-empted it.
  assign tmo_hit = in_wait && (({1'b0, tmo_cnt_q} + 17'd1) >= {1'b0, C_TIMEOUT});

  // Watchdog counter restarts on every state change; timeout flag is
  // reloaded whenever a new response is produced.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)                     tmo_cnt_d = '0;
    else if (in_wait && tmo_cnt_q != 16'hFFFF)  tmo_cnt_d = tmo_cnt_q + 16'd1;
    rsp_timeout_d = (rsp_valid_d && !rsp_valid_q) ? abort : rsp_timeout_q;
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign cmd_ready_o = (state_q == S_IDLE);
  assign bready_o    = (state_q == S_WR_RESP);
  assign rready_o    = (state_q == S_RD_DATA);
  assign awvalid_o   = awvalid_q;
  assign wvalid_o    = wvalid_q;
  assign arvalid_o   = arvalid_q;
  assign awaddr_o    = awaddr_q;
  assign wdata_o     = wdata_q;
  assign araddr_o    = araddr_q;
  assign awprot_o    = C_PROT;
  assign arprot_o    = C_PROT;
  assign wstrb_o     = C_WSTRB;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

endmodule
